fir_serial_tx: RTL

Parallel-to-serial transmitter on the FIR output path. Accepts a DATA_WIDTH-bit filtered sample from the FIR datapath over a valid/ready handshake and buffers it in a 1-deep holding register. It offers the sample on the serial o_dout/o_dout_valid/i_ready interface, then shifts it out one bit per clock. This is the transmit end of the serial output link that downstream logic and the testbench capture.

---
 rtl/fir_serial_tx.sv | 122 ++++++++++++
 1 files changed

// File: rtl/fir_serial_tx.sv
// fir_serial_tx: parallel-to-serial transmitter on the FIR output path.
// A 1-deep holding register decouples the FIR datapath from the serial
// shifter, so the next sample can be parked while the current one shifts out.
module fir_serial_tx #(
    parameter int DATA_WIDTH = 24,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_word,
    input  logic                  i_word_valid,
    output logic                  o_word_ready,
    input  logic                  i_ready,
    output logic                  o_dout,
    output logic                  o_dout_valid,
    output logic                  o_busy
);

    localparam int               CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam int               OUT_IDX  = LSB_FIRST ? 0 : DATA_WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OFFER = 2'd1,
        S_SHIFT = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] hold_q;
    logic                  hold_full;
    logic [DATA_WIDTH-1:0] shreg_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  load_sh;
    logic                  shift_en;
    logic                  cnt_clr;
    logic                  accept;

    // Ready depends only on registered occupancy, never on i_word_valid.
    assign o_word_ready = !hold_full && i_en && !i_rst;
    assign accept       = i_word_valid && o_word_ready;

    // Outputs are decoded from registered state, so they freeze with i_en.
    assign o_dout_valid = (state_q == S_OFFER);
    assign o_dout       = (state_q == S_SHIFT) && shreg_q[OUT_IDX];
    assign o_busy       = hold_full || (state_q != S_IDLE);

    // Next-state and shifter control; nothing moves while i_en is low.
    always_comb begin
        state_nxt = state_q;
        load_sh   = 1'b0;
        shift_en  = 1'b0;
        cnt_clr   = 1'b0;
        if (i_en) begin
            case (state_q)
                S_IDLE: begin
                    if (hold_full) begin
                        load_sh   = 1'b1;
                        state_nxt = S_OFFER;
                    end
                end
                S_OFFER: begin
                    if (i_ready) begin
                        cnt_clr   = 1'b1;
                        state_nxt = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    shift_en = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        if (hold_full) begin
                            load_sh   = 1'b1;
                            state_nxt = S_OFFER;
                        end else begin
                            state_nxt = S_IDLE;
                        end
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= S_IDLE;
        else       state_q <= state_nxt;
    end

    // Holding register: fill from upstream, drain into the shifter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hold_q    <= '0;
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_q    <= i_word;
            hold_full <= 1'b1;
        end else if (load_sh) begin
            hold_full <= 1'b0;
        end
    end

    // Shift register and bit counter; a fresh load wins over the final shift.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (load_sh) begin
            shreg_q <= hold_q;
            cnt_q   <= '0;
        end else if (shift_en) begin
            shreg_q <= LSB_FIRST ? {1'b0, shreg_q[DATA_WIDTH-1:1]}
                                 : {shreg_q[DATA_WIDTH-2:0], 1'b0};
            cnt_q   <= cnt_q + CNT_W'(1);
        end else if (cnt_clr) begin
            cnt_q   <= '0;
        end
    end

endmodule
